// File: rtl/jogador_automatico_pkg.sv
// Shared definitions for the automatic memory-game player: state codes,
// default timing constants and a one-hot helper.
package jogador_automatico_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    ESPERA    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4
  } estado_t;

  localparam int MAX_JOG_PADRAO = 16;
  localparam int T_WAIT_PADRAO  = 10;
  localparam int T_PRESS_PADRAO = 10;
  localparam int T_GAP_PADRAO   = 10;

  function automatic logic eh_one_hot(input logic [3:0] valor);
    return (valor != 4'b0000) && ((valor & (valor - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/jogador_automatico_temporizador.sv
// Loadable down-counter shared by the wait, press and release phases.
// It stops at zero and flags it on fim.
module temporizador_jogador (
  input  logic       clock,
  input  logic       reset,
  input  logic       carrega,
  input  logic [7:0] valor,
  output logic       fim
);

  logic [7:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= 8'd0;
    end else if (carrega) begin
      contagem <= valor;
    end else if (contagem != 8'd0) begin
      contagem <= contagem - 8'd1;
    end
  end

  assign fim = (contagem == 8'd0);

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED sequence shown by the game and replays it
// on botoes with fixed press/release timing.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int MAX_JOG = MAX_JOG_PADRAO,
  parameter int T_WAIT  = T_WAIT_PADRAO,
  parameter int T_PRESS = T_PRESS_PADRAO,
  parameter int T_GAP   = T_GAP_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       mostra_leds,
  input  logic       pronto,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic [4:0] n_gravadas,
  output logic       erro_captura,
  output logic [3:0] db_estado
);

  localparam int IW = $clog2(MAX_JOG);

  estado_t       estado, estado_prox;
  logic [3:0]    leds_q;
  logic          mostra_q;
  logic [3:0]    buf_jog [MAX_JOG];
  logic [IW-1:0] idx, idx_prox;

  logic       zera_n, grava, marca_erro, zera_idx, inc_idx;
  logic       carrega, fim;
  logic [7:0] valor;
  logic       nova_tecla, mostra_sobe, em_replay;

  assign nova_tecla  = (leds_q == 4'b0000) && (leds != 4'b0000);
  assign mostra_sobe = mostra_leds && !mostra_q;
  assign em_replay   = (estado == ESPERA) || (estado == PRESSIONA) || (estado == SOLTA);

  temporizador_jogador u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (valor),
    .fim     (fim)
  );

  // Timer is loaded with T-1 so each phase lasts exactly T cycles, ending on fim.
  always_comb begin
    estado_prox = estado;
    zera_n      = 1'b0;
    grava       = 1'b0;
    marca_erro  = 1'b0;
    zera_idx    = 1'b0;
    inc_idx     = 1'b0;
    carrega     = 1'b0;
    valor       = 8'd0;

    if (!habilitar) begin
      estado_prox = OCIOSO;
    end else if (pronto) begin
      estado_prox = OCIOSO;
      zera_n      = 1'b1;
    end else if (mostra_sobe && em_replay) begin
      estado_prox = CAPTURA;
      zera_n      = 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          if (mostra_leds) begin
            estado_prox = CAPTURA;
            zera_n      = 1'b1;
          end
        end
        CAPTURA: begin
          if (mostra_leds) begin
            if (nova_tecla) begin
              if (!eh_one_hot(leds) || (n_gravadas == 5'(MAX_JOG))) begin
                marca_erro = 1'b1;
              end else begin
                grava = 1'b1;
              end
            end
          end else if (n_gravadas != 5'd0) begin
            estado_prox = ESPERA;
            carrega     = 1'b1;
            valor       = 8'(T_WAIT - 1);
          end else begin
            estado_prox = OCIOSO;
          end
        end
        ESPERA: begin
          if (fim) begin
            estado_prox = PRESSIONA;
            zera_idx    = 1'b1;
            carrega     = 1'b1;
            valor       = 8'(T_PRESS - 1);
          end
        end
        PRESSIONA: begin
          if (fim) begin
            estado_prox = SOLTA;
            carrega     = 1'b1;
            valor       = 8'(T_GAP - 1);
          end
        end
        SOLTA: begin
          if (fim) begin
            if ((5'(idx) + 5'd1) < n_gravadas) begin
              estado_prox = PRESSIONA;
              inc_idx     = 1'b1;
              carrega     = 1'b1;
              valor       = 8'(T_PRESS - 1);
            end else begin
              estado_prox = OCIOSO;
            end
          end
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  always_comb begin
    idx_prox = idx;
    if (zera_idx) begin
      idx_prox = '0;
    end else if (inc_idx) begin
      idx_prox = idx + 1'b1;
    end
  end

  // botoes follows the next state so the press lines up with PRESSIONA itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      botoes       <= 4'b0000;
      n_gravadas   <= 5'd0;
      erro_captura <= 1'b0;
      idx          <= '0;
      leds_q       <= 4'b0000;
      mostra_q     <= 1'b0;
    end else begin
      estado   <= estado_prox;
      leds_q   <= leds;
      mostra_q <= mostra_leds;
      idx      <= idx_prox;
      botoes   <= (estado_prox == PRESSIONA) ? buf_jog[idx_prox] : 4'b0000;
      if (zera_n) begin
        n_gravadas <= 5'd0;
      end else if (grava) begin
        n_gravadas <= n_gravadas + 5'd1;
      end
      if (marca_erro) begin
        erro_captura <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (grava) begin
      buf_jog[n_gravadas[IW-1:0]] <= leds;
    end
  end

  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: expected botoes transitions are
// queued with their cycle numbers and matched by an independent monitor.
module tb_jogador_automatico;
  import jogador_automatico_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilitar = 1'b1;
  logic [3:0] leds = 4'b0000;
  logic       mostra_leds = 1'b0;
  logic       pronto = 1'b0;
  logic [3:0] botoes;
  logic       ocupado;
  logic [4:0] n_gravadas;
  logic       erro_captura;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] valor;
    int         ciclo;
  } evento_t;

  evento_t    fila[$];
  logic [3:0] prev_botoes = 4'b0000;
  logic [3:0] mostrar[$];
  logic [3:0] esperado[$];
  logic [3:0] rodizio[4];

  jogador_automatico dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .leds         (leds),
    .mostra_leds  (mostra_leds),
    .pronto       (pronto),
    .botoes       (botoes),
    .ocupado      (ocupado),
    .n_gravadas   (n_gravadas),
    .erro_captura (erro_captura),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every change seen on botoes must match the oldest queued expectation.
  always @(negedge clock) begin
    if (botoes !== prev_botoes) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("[TB] FAIL botoes_inesperado: got %b at cycle %0d, expected no change", botoes, cyc);
      end else begin
        evento_t e;
        e = fila.pop_front();
        if ((botoes !== e.valor) || (cyc != e.ciclo)) begin
          errors++;
          $display("[TB] FAIL botoes_evento: got %b at cycle %0d, expected %b at cycle %0d",
                   botoes, cyc, e.valor, e.ciclo);
        end
      end
      prev_botoes = botoes;
    end
  end

  task automatic check_output(input string nome, input int atual, input int requerido);
    checks++;
    if (atual != requerido) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, requerido);
    end
  endtask

  task automatic push_evento(input logic [3:0] v, input int c);
    evento_t e;
    e.valor = v;
    e.ciclo = c;
    fila.push_back(e);
  endtask

  task automatic push_replay(input int k);
    foreach (esperado[i]) begin
      push_evento(esperado[i], k + T_WAIT_PADRAO + 1 + i * (T_PRESS_PADRAO + T_GAP_PADRAO));
      push_evento(4'b0000, k + T_WAIT_PADRAO + 1 + T_PRESS_PADRAO + i * (T_PRESS_PADRAO + T_GAP_PADRAO));
    end
  endtask

  task automatic start_show();
    @(negedge clock);
    mostra_leds = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic show_item(input logic [3:0] code);
    @(negedge clock);
    leds = code;
    repeat (3) @(negedge clock);
    leds = 4'b0000;
    @(negedge clock);
  endtask

  task automatic end_show(output int k);
    @(negedge clock);
    mostra_leds = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (db_estado == 4'(OCIOSO)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_ocioso: got state %0d, expected %0d within %0d cycles",
               db_estado, 0, budget);
    end
  endtask

  task automatic apply_stimulus();
    int k;
    start_show();
    foreach (mostrar[i]) show_item(mostrar[i]);
    end_show(k);
    push_replay(k);
    wait_idle(600);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int k;
    rodizio = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    #1;
    check_output("reset_botoes", int'(botoes), 0);
    check_output("reset_estado", int'(db_estado), int'(OCIOSO));
    check_output("reset_ocupado", int'(ocupado), 0);
    check_output("reset_n", int'(n_gravadas), 0);
    check_output("reset_erro", int'(erro_captura), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    $display("[TB] single item 0001");
    mostrar = '{4'b0001};
    esperado = '{4'b0001};
    apply_stimulus();
    check_output("t2_n", int'(n_gravadas), 1);
    check_output("t2_estado", int'(db_estado), int'(OCIOSO));
    check_output("t2_erro", int'(erro_captura), 0);

    $display("[TB] two items 0001,1000");
    mostrar = '{4'b0001, 4'b1000};
    esperado = '{4'b0001, 4'b1000};
    apply_stimulus();
    check_output("t3_n", int'(n_gravadas), 2);

    $display("[TB] overflow with 17 items");
    start_show();
    for (int i = 0; i < 16; i++) show_item(rodizio[i % 4]);
    check_output("t4_n16", int'(n_gravadas), 16);
    check_output("t4_erro_antes", int'(erro_captura), 0);
    show_item(4'b0001);
    check_output("t4_n_cheio", int'(n_gravadas), 16);
    check_output("t4_erro_overflow", int'(erro_captura), 1);
    end_show(k);
    esperado.delete();
    for (int i = 0; i < 16; i++) esperado.push_back(rodizio[i % 4]);
    push_replay(k);
    wait_idle(600);

    $display("[TB] non one-hot code");
    apply_reset();
    mostrar = '{4'b0100, 4'b0011, 4'b0010};
    esperado = '{4'b0100, 4'b0010};
    apply_stimulus();
    check_output("t4_erro_onehot", int'(erro_captura), 1);
    check_output("t4_n_onehot", int'(n_gravadas), 2);

    $display("[TB] mostra_leds rises during SOLTA");
    start_show();
    show_item(4'b0001);
    show_item(4'b0010);
    end_show(k);
    push_evento(4'b0001, k + 11);
    push_evento(4'b0000, k + 21);
    while (cyc < k + 24) @(negedge clock);
    mostra_leds = 1'b1;
    @(negedge clock);
    check_output("t5_estado_captura", int'(db_estado), int'(CAPTURA));
    check_output("t5_botoes", int'(botoes), 0);
    check_output("t5_n_zero", int'(n_gravadas), 0);
    show_item(4'b1000);
    end_show(k);
    esperado = '{4'b1000};
    push_replay(k);
    wait_idle(600);
    check_output("t5_n_recaptura", int'(n_gravadas), 1);

    $display("[TB] pronto during PRESSIONA");
    start_show();
    show_item(4'b0100);
    end_show(k);
    push_evento(4'b0100, k + 11);
    push_evento(4'b0000, k + 14);
    while (cyc < k + 13) @(negedge clock);
    pronto = 1'b1;
    @(negedge clock);
    check_output("t5_pronto_estado", int'(db_estado), int'(OCIOSO));
    check_output("t5_pronto_botoes", int'(botoes), 0);
    check_output("t5_pronto_n", int'(n_gravadas), 0);
    pronto = 1'b0;

    $display("[TB] habilitar low during CAPTURA");
    start_show();
    check_output("t6_estado_captura", int'(db_estado), int'(CAPTURA));
    check_output("t6_ocupado", int'(ocupado), 1);
    habilitar = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      leds = rodizio[i];
      @(negedge clock);
      check_output("t6_estado_ocioso", int'(db_estado), int'(OCIOSO));
      leds = 4'b0000;
      @(negedge clock);
    end
    check_output("t6_n", int'(n_gravadas), 0);
    mostra_leds = 1'b0;
    habilitar = 1'b1;
    repeat (2) @(negedge clock);
    check_output("t6_estado_final", int'(db_estado), int'(OCIOSO));

    $display("[TB] asynchronous reset during PRESSIONA");
    start_show();
    show_item(4'b0010);
    end_show(k);
    push_evento(4'b0010, k + 11);
    push_evento(4'b0000, k + 14);
    while (cyc < k + 13) @(negedge clock);
    check_output("t1_estado_antes", int'(db_estado), int'(PRESSIONA));
    check_output("t1_erro_antes", int'(erro_captura), 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("t1_botoes", int'(botoes), 0);
    check_output("t1_estado", int'(db_estado), int'(OCIOSO));
    check_output("t1_erro", int'(erro_captura), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_output("fila_vazia", fila.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
